// File: rtl/fetch_queue.sv
// fetch_queue
//   Circular instruction buffer between fetch (writer) and decode (reader).
//   One push and one pop per cycle over valid/ready handshakes; flush empties
//   the queue in one cycle. Outputs are combinational from registered state.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   flush      synchronous clear of all entries (branch recovery)
//   in_valid   fetch presents in_data
//   in_ready   queue accepts a push this cycle (count != DEPTH)
//   in_data    entry to push
//   out_valid  head entry available (count != 0)
//   out_ready  decode consumes the head this cycle
//   out_data   head entry, 0 while empty
//   count      current occupancy, 0..DEPTH
module fetch_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             push;
    logic             pop;

    // in_ready depends only on registered count, so a full queue refuses a
    // push even when decode pops in the same cycle.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[head] : '0;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage has no reset; writes are suppressed whenever the pointer
    // update is overridden so stale data can never be attributed to a push.
    always_ff @(posedge clk) begin
        if (reset && !flush && push) begin
            mem[tail] <= in_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        e_irdy;
        logic        e_ovld;
        logic [31:0] e_data;
        int          e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs, clock one edge, then settle just after the edge.
    task automatic tick(input logic r, input logic f, input logic iv,
                        input logic [31:0] d, input logic ordy);
        reset     = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic e_irdy, input logic e_ovld,
                           input logic [31:0] e_data, input int e_cnt);
        chk({tag, ".in_ready"},  32'(in_ready),  32'(e_irdy));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ovld));
        chk({tag, ".out_data"},  out_data,       e_data);
        chk({tag, ".count"},     32'(count),     32'(e_cnt));
    endtask

    function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                                input logic [31:0] d, input logic ordy,
                                input logic e_irdy, input logic e_ovld,
                                input logic [31:0] e_data, input int e_cnt);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_irdy = e_irdy; v.e_ovld = e_ovld; v.e_data = e_data; v.e_cnt = e_cnt;
        return v;
    endfunction

    initial begin : main
        logic [31:0] exp_d;
        logic [31:0] wd;

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Vector table: reset, fill, refused 9th push, drain in order.
        vecs.push_back(mk(0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(1, 0, 1, 32'h11 * i, 0, (i < 8), 1, 32'h11, i));
        vecs.push_back(mk(1, 0, 1, 32'h99, 0, 0, 1, 32'h11, 8));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(1, 0, 0, 32'h0, 1, 1, (k < 8),
                              (k < 8) ? 32'h11 * (k + 1) : 32'h0, 8 - k));

        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            chk_all($sformatf("vec%0d", i), vecs[i].e_irdy, vecs[i].e_ovld,
                    vecs[i].e_data, vecs[i].e_cnt);
        end

        // Steady push+pop at count 3 across pointer wrap.
        for (int i = 1; i <= 3; i++) tick(1, 0, 1, 32'(i), 0);
        chk_all("wrap_pre", 1, 1, 32'd1, 3);
        exp_d = 32'd1;
        for (int i = 0; i < 20; i++) begin
            tick(1, 0, 1, 32'(4 + i), 1);
            exp_d = exp_d + 1;
            chk("wrap.count", 32'(count), 32'd3);
            chk("wrap.out_data", out_data, exp_d);
        end

        // Fill to 8 (queue holds 21..28), then pop+push while full.
        for (int i = 24; i <= 28; i++) tick(1, 0, 1, 32'(i), 0);
        chk_all("full_pre", 0, 1, 32'd21, 8);
        tick(1, 0, 1, 32'd29, 1);
        chk_all("full_pop", 1, 1, 32'd22, 7);
        tick(1, 0, 1, 32'd29, 0);
        chk_all("full_refill", 0, 1, 32'd22, 8);
        for (int i = 0; i < 8; i++) begin
            chk("full_drain.out_data", out_data, 32'(22 + i));
            tick(1, 0, 0, 32'h0, 1);
        end
        chk_all("full_empty", 1, 0, 32'h0, 0);

        // Flush mid-stream discards the concurrent push and pop.
        for (int i = 0; i < 5; i++) tick(1, 0, 1, 32'h50 + 32'(i), 0);
        chk("flush_pre.count", 32'(count), 32'd5);
        tick(1, 1, 1, 32'hEE, 1);
        chk_all("flush", 1, 0, 32'h0, 0);
        tick(1, 0, 1, 32'hAB, 0);
        chk_all("flush_push", 1, 1, 32'hAB, 1);
        tick(1, 0, 0, 32'h0, 1);
        chk_all("flush_pop", 1, 0, 32'h0, 0);

        // Reset mid-operation overrides handshakes.
        for (int i = 0; i < 6; i++) tick(1, 0, 1, 32'h60 + 32'(i), 0);
        chk_all("rst_pre", 1, 1, 32'h60, 6);
        tick(0, 0, 1, 32'hCC, 1);
        chk_all("rst_mid", 1, 0, 32'h0, 0);
        tick(1, 0, 0, 32'h0, 1);
        chk_all("rst_idle", 1, 0, 32'h0, 0);
        wd = 32'h77;
        tick(1, 0, 1, wd, 0);
        chk_all("rst_push", 1, 1, 32'h77, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Circular instruction buffer between the fetch stage (writer) and the decode stage (reader) of the out-of-order core. Fetch pushes one entry per cycle and decode pops one entry per cycle, each over a valid/ready handshake. The queue decouples fetch stalls from decode stalls. A flush from branch recovery empties it in one cycle.

## Interface
- WIDTH, 32, bits per entry (instruction word)
- DEPTH, 8, number of entries; power of two, >= 2
- CW, $clog2(DEPTH)+1, width of the occupancy count (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-low reset; sampled on posedge clk
- flush  input  1  synchronous clear of all entries (branch mispredict recovery)
- in_valid  input  1  fetch presents in_data
- in_ready  output  1  queue accepts a push this cycle
- in_data  input  WIDTH  entry to push
- out_valid  output  1  head entry available to decode
- out_ready  input  1  decode consumes the head this cycle
- out_data  output  WIDTH  head entry
- count  output  CW  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH x WIDTH array, head (read) pointer, tail (write) pointer, each log2(DEPTH) bits. Pointers wrap modulo DEPTH. Occupancy is held in the count register.
- Push occurs when in_valid && in_ready: mem[tail] <= in_data and tail <= tail+1.
- Pop occurs when out_valid && out_ready: head <= head+1.
- in_ready = (count != DEPTH). It does not depend on out_ready, so there is no combinational path from decode to fetch. When full, a push is refused even if a pop happens in the same cycle.
- out_valid = (count != 0).
- out_data = mem[head] when out_valid=1, and 0 when out_valid=0. This value is combinational from registered state.
- Count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on push and pop together, or when neither occurs
- Push and pop in the same cycle are legal whenever 0 < count < DEPTH.
- Priority, highest first: reset (low), then flush, then push/pop.
- flush=1 (with reset high):
  - next cycle: head=tail=0 and count=0
  - any push or pop in the flush cycle is discarded
  - array contents are not cleared
- Reset low: head=tail=count=0 on the next edge. This holds mid-operation and overrides flush and handshakes.
- Array contents are not reset. They are never observable because out_data is forced to 0 while empty.
- No error outputs. Push when full and pop when empty cannot occur, because the ready/valid gating blocks them.

## Timing
- Reset values of the outputs (the cycle after an edge with reset=0): in_ready=1, out_valid=0, out_data=0, count=0.
- Push-to-visible latency is 1 cycle. An entry pushed at edge N appears on out_data, with out_valid=1, after edge N. There is no fall-through in the push cycle, even when the queue is empty.
- A pop at edge N presents the next entry, or out_valid=0, after edge N.
- Flush takes effect at the edge it is sampled on. After that edge: out_valid=0, in_ready=1, count=0. Pushes are accepted again in the following cycle.
- Full: the push that makes count=DEPTH drops in_ready after that edge. in_ready returns high the cycle after the first pop.
- Wrap-around: tail and head roll from DEPTH-1 to 0 with no bubble.
- The registered state is {head, tail, count, mem}. All outputs are combinational from that state only.

## Test plan
- Reset then fill: reset=0 for 2 cycles, then reset=1. Push 0x11..0x88 (DEPTH=8) with out_ready=0 -> count steps 1..8. in_ready=0 after the 8th push. A 9th push of 0x99 is held off and not stored.
- Drain order: from full, out_ready=1 for 8 cycles -> out_data 0x11,0x22,...,0x88 in order. Then out_valid=0, out_data=0, count=0.
- Simultaneous push/pop with wrap: keep count=3 while pushing and popping every cycle for 20 cycles, with incrementing data -> count stays 3 and output order is strictly incrementing across pointer wrap.
- Full with pop: at count=8, in_valid=1 and out_ready=1 -> pop happens, push is refused, and count goes to 7. Next cycle the push is accepted and count returns to 8.
- Flush mid-stream: at count=5, assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0, in_ready=1. Push 0xAB -> out_data=0xAB one cycle later.
- Reset mid-operation: at count=6, drive reset=0 together with flush=0, in_valid=1 and out_ready=1 -> after the edge count=0, out_valid=0, out_data=0, in_ready=1. Nothing from before the reset reappears.
